// File: rtl/operand_fetch.sv
// operand_fetch: issue/operand-fetch stage between the decoder and execute.
//
// Takes one decoded instruction per cycle and drives the register-file read
// addresses from its sources. Same-cycle writeback data is forwarded into the
// operands. An NREG-entry pending-write scoreboard blocks RAW/WAW hazards. The
// operand bundle goes to execute in registers over a valid/ready handshake.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready              decoder handshake
//   in_op/in_src1/in_src2/in_dst   decoded fields
//   in_wen                         instruction writes in_dst
//   rf_raddr1/2, rf_rdata1/2       register-file read ports (combinational)
//   wb_valid/wb_addr/wb_data       writeback into the register file
//   flush                          discard the held output bundle
//   out_valid/out_ready            execute-stage handshake
//   out_op/out_a/out_b/out_dst/out_wen  registered operand bundle
//   busy_map                       pending-write bits, one per register
//   stall_cnt                      saturating count of hazard-stall cycles
//   err_wb                         sticky: writeback to a non-pending register
module operand_fetch #(
  parameter int DW   = 32,
  parameter int AW   = 3,
  parameter int NREG = 8,
  parameter int SCW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_op,
  input  logic [AW-1:0]   in_src1,
  input  logic [AW-1:0]   in_src2,
  input  logic [AW-1:0]   in_dst,
  input  logic            in_wen,
  output logic [AW-1:0]   rf_raddr1,
  output logic [AW-1:0]   rf_raddr2,
  input  logic [DW-1:0]   rf_rdata1,
  input  logic [DW-1:0]   rf_rdata2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [DW-1:0]   wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_op,
  output logic [DW-1:0]   out_a,
  output logic [DW-1:0]   out_b,
  output logic [AW-1:0]   out_dst,
  output logic            out_wen,
  output logic [NREG-1:0] busy_map,
  output logic [SCW-1:0]  stall_cnt,
  output logic            err_wb
);

  logic            wbHit1, wbHit2, wbHitDst;
  logic            src1Clear, src2Clear, dstClear;
  logic            hazard, accept, flushRelease;
  logic [DW-1:0]   opA, opB;
  logic [NREG-1:0] busyNext;

  assign rf_raddr1 = in_src1;
  assign rf_raddr2 = in_src2;

  assign wbHit1   = wb_valid && (wb_addr == in_src1);
  assign wbHit2   = wb_valid && (wb_addr == in_src2);
  assign wbHitDst = wb_valid && (wb_addr == in_dst);

  assign opA = wbHit1 ? wb_data : rf_rdata1;
  assign opB = wbHit2 ? wb_data : rf_rdata2;

  // A register being written back this cycle is treated as already free.
  assign src1Clear = !busy_map[in_src1] || wbHit1;
  assign src2Clear = !busy_map[in_src2] || wbHit2;
  assign dstClear  = !busy_map[in_dst]  || wbHitDst;

  assign hazard   = in_valid && (!src1Clear || !src2Clear || (in_wen && !dstClear));
  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // A flushed bundle will never write back, so its pending bit is returned.
  assign flushRelease = flush && out_valid && out_wen;

  // A new reservation wins over any clear of the same register this cycle.
  always_comb begin
    busyNext = busy_map;
    for (int r = 0; r < NREG; r++) begin
      if (accept && in_wen && (in_dst == AW'(r)))
        busyNext[r] = 1'b1;
      else if (wb_valid && (wb_addr == AW'(r)))
        busyNext[r] = 1'b0;
      else if (flushRelease && (out_dst == AW'(r)))
        busyNext[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_dst   <= '0;
      out_wen   <= 1'b0;
      busy_map  <= '0;
      stall_cnt <= '0;
      err_wb    <= 1'b0;
    end else begin
      busy_map <= busyNext;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_op    <= in_op;
        out_a     <= opA;
        out_b     <= opB;
        out_dst   <= in_dst;
        out_wen   <= in_wen;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (hazard && (stall_cnt != {SCW{1'b1}}))
        stall_cnt <= stall_cnt + SCW'(1);

      if (wb_valid && !busy_map[wb_addr])
        err_wb <= 1'b1;
    end
  end

endmodule
